// File: rtl/hazard_sched.sv
// Hazard scheduler: EX/MEM/WB destination shadow, operand forwarding selects, load-use/mem-wait/flush sequencing.
// Forwarding and controls are combinational from state and ID inputs; the scheduler itself has no backpressure and it freezes while mem_busy is high.
module hazard_sched #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_rd_wen,
  input  logic                      id_is_load,
  input  logic                      mem_busy,
  input  logic                      branch_flush,
  output logic                      stall_if_id,
  output logic                      bubble_ex,
  output logic                      freeze_all,
  output logic [1:0]                fwd_rs1_sel,
  output logic [1:0]                fwd_rs2_sel,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  typedef struct packed {
    logic                      vld;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      wen;
    logic                      is_load;
  } slot_t;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LU_STALL   = 2'd1;
  localparam logic [1:0] ST_MEM_FREEZE = 2'd2;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0] state, state_nxt;
  slot_t      ex_slot, mem_slot, wb_slot;
  slot_t      new_slot, id_slot;
  logic       shift;
  logic       stall_c, bubble_c, freeze_c;

  logic ex_rs1, mem_rs1, wb_rs1;
  logic ex_rs2, mem_rs2, wb_rs2;
  logic load_use;

  // x0 is hardwired zero, so a write to it never needs forwarding.
  function automatic logic slot_match(input slot_t s,
                                      input logic [REG_ADDR_WIDTH-1:0] rs,
                                      input logic rd_req);
    return s.vld & s.wen & (s.rd == rs) & (rs != '0) & rd_req;
  endfunction

  assign ex_rs1  = slot_match(ex_slot,  id_rs1, id_rs1_used & id_valid);
  assign mem_rs1 = slot_match(mem_slot, id_rs1, id_rs1_used & id_valid);
  assign wb_rs1  = slot_match(wb_slot,  id_rs1, id_rs1_used & id_valid);
  assign ex_rs2  = slot_match(ex_slot,  id_rs2, id_rs2_used & id_valid);
  assign mem_rs2 = slot_match(mem_slot, id_rs2, id_rs2_used & id_valid);
  assign wb_rs2  = slot_match(wb_slot,  id_rs2, id_rs2_used & id_valid);

  assign load_use = ex_slot.is_load & (ex_rs1 | ex_rs2);

  always_comb begin
    fwd_rs1_sel = SEL_RF;
    if (ex_rs1)       fwd_rs1_sel = SEL_EX;
    else if (mem_rs1) fwd_rs1_sel = SEL_MEM;
    else if (wb_rs1)  fwd_rs1_sel = SEL_WB;
  end

  always_comb begin
    fwd_rs2_sel = SEL_RF;
    if (ex_rs2)       fwd_rs2_sel = SEL_EX;
    else if (mem_rs2) fwd_rs2_sel = SEL_MEM;
    else if (wb_rs2)  fwd_rs2_sel = SEL_WB;
  end

  assign id_slot = '{vld: id_valid, rd: id_rd, wen: id_rd_wen, is_load: id_is_load};

  // Priority within RUN: memory wait, then flush, then load-use.
  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    freeze_c  = 1'b0;
    shift     = 1'b0;
    new_slot  = '0;
    case (state)
      ST_RUN: begin
        if (mem_busy) begin
          state_nxt = ST_MEM_FREEZE;
        end else if (branch_flush) begin
          bubble_c = 1'b1;
          shift    = 1'b1;
        end else if (load_use) begin
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          shift     = 1'b1;
          state_nxt = ST_LU_STALL;
        end else begin
          shift    = 1'b1;
          new_slot = id_slot;
        end
      end
      ST_LU_STALL: begin
        if (mem_busy) begin
          state_nxt = ST_MEM_FREEZE;
        end else begin
          shift     = 1'b1;
          new_slot  = id_slot;
          state_nxt = ST_RUN;
        end
      end
      ST_MEM_FREEZE: begin
        freeze_c = 1'b1;
        stall_c  = 1'b1;
        if (!mem_busy) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign stall_if_id = stall_c  & ~rst;
  assign bubble_ex   = bubble_c & ~rst;
  assign freeze_all  = freeze_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else begin
      state <= state_nxt;
      if (shift) begin
        wb_slot  <= mem_slot;
        mem_slot <= ex_slot;
        ex_slot  <= new_slot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((stall_c | freeze_c) && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed scenarios plus random traffic against a stage-list reference model.
module tb_hazard_sched;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_rd_wen = 1'b0, id_is_load = 1'b0;
  logic          mem_busy = 1'b0, branch_flush = 1'b0;
  logic          stall_if_id, bubble_ex, freeze_all;
  logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_sched #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .mem_busy(mem_busy),
    .branch_flush(branch_flush), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .freeze_all(freeze_all), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_cnt(stall_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct { bit vld; int rd; bit wen; bit ld; } ent_t;
  ent_t   pipe [3];
  int     mode;  // 0 running, 1 just stalled for a load, 2 waiting on memory
  longint cnt;

  logic          obs_stall, obs_bubble, obs_freeze;
  logic [1:0]    obs_f1, obs_f2;
  logic [CW-1:0] obs_cnt;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    mode = 0;
    cnt  = 0;
  endtask

  // Nearest older producer of rs, as stage distance 1..3; 0 means register file.
  function automatic int exp_fwd(input int rs, input bit used);
    if (!id_valid || !used || rs == 0) return 0;
    for (int d = 0; d < 3; d++)
      if (pipe[d].vld && pipe[d].wen && pipe[d].rd == rs) return d + 1;
    return 0;
  endfunction

  task automatic step(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                      input int rd, input bit wen, input bit ld, input bit busy, input bit flush);
    bit   e_stall, e_bubble, e_freeze, adv, hz;
    int   e1, e2, mode_n;
    ent_t nw;
    id_valid = v; id_rs1 = r1[AW-1:0]; id_rs1_used = u1;
    id_rs2 = r2[AW-1:0]; id_rs2_used = u2;
    id_rd = rd[AW-1:0]; id_rd_wen = wen; id_is_load = ld;
    mem_busy = busy; branch_flush = flush;
    #2;
    e1 = exp_fwd(r1, u1);
    e2 = exp_fwd(r2, u2);
    hz = pipe[0].ld && (e1 == 1 || e2 == 1);
    e_stall = 0; e_bubble = 0; e_freeze = 0; adv = 0; nw = '{0, 0, 0, 0}; mode_n = mode;
    if (mode == 2) begin
      e_freeze = 1; e_stall = 1;
      if (!busy) mode_n = 0;
    end else if (busy) begin
      mode_n = 2;
    end else if (mode == 1) begin
      adv = 1; nw = '{v, rd, wen, ld}; mode_n = 0;
    end else if (flush) begin
      e_bubble = 1; adv = 1;
    end else if (hz) begin
      e_stall = 1; e_bubble = 1; adv = 1; mode_n = 1;
    end else begin
      adv = 1; nw = '{v, rd, wen, ld};
    end
    obs_stall = stall_if_id; obs_bubble = bubble_ex; obs_freeze = freeze_all;
    obs_f1 = fwd_rs1_sel; obs_f2 = fwd_rs2_sel; obs_cnt = stall_cnt;
    check("fwd_rs1", 64'(obs_f1), 64'(e1));
    check("fwd_rs2", 64'(obs_f2), 64'(e2));
    check("stall", 64'(obs_stall), 64'(e_stall));
    check("bubble", 64'(obs_bubble), 64'(e_bubble));
    check("freeze", 64'(obs_freeze), 64'(e_freeze));
    check("cnt", 64'(obs_cnt), 64'(cnt));
    @(posedge clk);
    if (adv) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nw;
    end
    if ((e_stall || e_freeze) && cnt < CMAX) cnt++;
    mode = mode_n;
    @(negedge clk);
  endtask

  initial begin
    int frz, c0, busy_left;
    bit b;
    model_reset();
    branch_flush = 1'b1;
    id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    #3;
    check("rst_stall", 64'(stall_if_id), 64'd0);
    check("rst_bubble", 64'(bubble_ex), 64'd0);
    check("rst_freeze", 64'(freeze_all), 64'd0);
    check("rst_fwd1", 64'(fwd_rs1_sel), 64'd0);
    check("rst_fwd2", 64'(fwd_rs2_sel), 64'd0);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ALU producer then consumer: EX forward, no stall
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    check("alu_fwd", 64'(obs_f1), 64'd1);
    check("alu_nostall", 64'(obs_stall), 64'd0);

    // load then user: one stall cycle, then MEM forward
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    check("lu_stall", 64'(obs_stall), 64'd1);
    check("lu_bubble", 64'(obs_bubble), 64'd1);
    step(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    check("lu_fwd_mem", 64'(obs_f1), 64'd2);
    check("lu_release", 64'(obs_stall), 64'd0);
    check("lu_cnt", 64'(obs_cnt), 64'd1);

    // three producers of x3; repeated consumer sees EX, then MEM, then WB
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 3, 1, 3, 1, 9, 0, 0, 0, 0);
      check("prio_rs1", 64'(obs_f1), 64'(i));
      check("prio_rs2", 64'(obs_f2), 64'(i));
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 9, 0, 0, 0, 0);
    check("x0_rs1", 64'(obs_f1), 64'd0);
    check("x0_rs2", 64'(obs_f2), 64'd0);

    // mem_busy for 4 cycles starting in the load-use stall
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    step(1, 7, 1, 0, 0, 8, 1, 0, 1, 0);
    c0 = int'(obs_cnt);
    frz = int'(obs_freeze);
    for (int i = 0; i < 3; i++) begin
      step(1, 7, 1, 0, 0, 8, 1, 0, 1, 0);
      frz += int'(obs_freeze);
      check("frz_hold_fwd", 64'(obs_f1), 64'd2);
    end
    step(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    frz += int'(obs_freeze);
    step(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    check("frz_cycles", 64'(frz), 64'd4);
    check("frz_run", 64'(obs_freeze), 64'd0);
    check("frz_cnt_delta", 64'(int'(obs_cnt) - c0), 64'd4);

    // flush and load-use together: bubble only, stays running
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    step(1, 9, 1, 0, 0, 4, 1, 0, 0, 1);
    check("flush_bubble", 64'(obs_bubble), 64'd1);
    check("flush_nostall", 64'(obs_stall), 64'd0);
    step(1, 9, 1, 0, 0, 4, 1, 0, 0, 0);
    check("flush_after", 64'(obs_stall), 64'd0);

    busy_left = 0;
    for (int n = 0; n < 2000; n++) begin
      if (busy_left > 0) begin
        b = 1; busy_left--;
      end else begin
        b = 0;
        if ($urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 5);
      end
      step(1'($urandom_range(0, 7) != 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), b,
           1'($urandom_range(0, 7) == 0));
    end

    // async reset while frozen
    step(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    check("pre_rst_freeze", 64'(obs_freeze), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_freeze", 64'(freeze_all), 64'd0);
    check("arst_stall", 64'(stall_if_id), 64'd0);
    check("arst_bubble", 64'(bubble_ex), 64'd0);
    check("arst_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // long memory wait drives the counter into saturation
    for (int n = 0; n < 300; n++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sat_cnt", 64'(obs_cnt), CMAX);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sat_hold", 64'(obs_cnt), CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
